game_round_controller: RTL

GAME_ROUND_CONTROLLER -- requirements
Module: game_round_controller

---
 rtl/game_round_controller.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/game_round_controller.sv
// Game round controller: round timer, score, level and lives bookkeeping
// for a prompt/response game. Optional lives support: GAME_ROUND_LIVES_EN.
module game_round_controller #(
    parameter int ROUND_TIME = 20,
    parameter int MIN_TIME   = 5,
    parameter int LEVEL_STEP = 5,
    parameter int MAX_LIVES  = 3
) (
    input  logic       clk1Hz,
    input  logic       reset_btn,
    input  logic       start,
    input  logic       pause,
    input  logic       pass_req,
    input  logic       fail_req,
    output logic       pass_ack,
    output logic       fail_ack,
    output logic       new_round,
    output logic [5:0] time_left,
    output logic [6:0] score,
    output logic [3:0] level,
    output logic [1:0] lives,
    output logic       timeout,
    output logic       game_over
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] PLAY      = 2'd1;
    localparam logic [1:0] PAUSED    = 2'd2;
    localparam logic [1:0] GAME_OVER = 2'd3;

    localparam logic [6:0] SCORE_MAX = 7'd99;
    localparam logic [3:0] LEVEL_MAX = 4'd9;
    localparam logic [6:0] CNT_LAST  = 7'(LEVEL_STEP - 1);

    // Round length for a level, floored at MIN_TIME without underflow.
    function automatic logic [5:0] round_time(input logic [3:0] lvl);
        int dec;
        dec = 2 * int'(lvl);
        if (ROUND_TIME > MIN_TIME + dec)
            round_time = 6'(ROUND_TIME - dec);
        else
            round_time = 6'(MIN_TIME);
    endfunction

    logic [1:0] r_state;
    logic [5:0] r_time;
    logic [6:0] r_score;
    logic [3:0] r_level;
    logic [6:0] r_round_cnt;
    logic       r_new_round;
    logic       r_pass_ack;
    logic       r_fail_ack;
    logic       r_timeout;
    logic       r_pass_seen;
    logic       r_fail_seen;

    logic [1:0] w_state_nxt;
    logic [5:0] w_time_nxt;
    logic [6:0] w_score_nxt;
    logic [3:0] w_level_nxt;
    logic [6:0] w_cnt_nxt;
    logic       w_nr_nxt;
    logic       w_pack_nxt;
    logic       w_fack_nxt;
    logic       w_tout_nxt;
    logic       w_pseen_nxt;
    logic       w_fseen_nxt;
    logic       w_lose;
    logic       w_pass_vld;
    logic       w_fail_vld;

`ifdef GAME_ROUND_LIVES_EN
    logic [1:0] r_lives;
    logic [1:0] w_lives_nxt;
`else
    logic [1:0] w_unused_lives;
    assign w_unused_lives = 2'(MAX_LIVES);
`endif

    // A request is only served once per assertion.
    assign w_pass_vld = pass_req & ~r_pass_seen;
    assign w_fail_vld = fail_req & ~r_fail_seen;

    // Next-state and counter update for the current cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_time_nxt  = r_time;
        w_score_nxt = r_score;
        w_level_nxt = r_level;
        w_cnt_nxt   = r_round_cnt;
        w_nr_nxt    = r_new_round;
        w_pack_nxt  = 1'b0;
        w_fack_nxt  = 1'b0;
        w_tout_nxt  = 1'b0;
        w_lose      = 1'b0;
`ifdef GAME_ROUND_LIVES_EN
        w_lives_nxt = r_lives;
`endif
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = PLAY;
                    w_time_nxt  = round_time(4'd0);
                    w_score_nxt = 7'd0;
                    w_level_nxt = 4'd0;
                    w_cnt_nxt   = 7'd0;
                    w_nr_nxt    = ~r_new_round;
`ifdef GAME_ROUND_LIVES_EN
                    w_lives_nxt = 2'(MAX_LIVES);
`endif
                end
            end
            PLAY: begin
                if (pause) begin
                    w_state_nxt = PAUSED;
                end else if (w_fail_vld) begin
                    w_fack_nxt = 1'b1;
                    w_pack_nxt = w_pass_vld;
                    w_lose     = 1'b1;
                end else if (w_pass_vld) begin
                    w_pack_nxt = 1'b1;
                    if (r_score != SCORE_MAX)
                        w_score_nxt = r_score + 7'd1;
                    if (r_round_cnt >= CNT_LAST) begin
                        w_cnt_nxt = 7'd0;
                        if (r_level != LEVEL_MAX)
                            w_level_nxt = r_level + 4'd1;
                    end else begin
                        w_cnt_nxt = r_round_cnt + 7'd1;
                    end
                    w_time_nxt = round_time(w_level_nxt);
                    w_nr_nxt   = ~r_new_round;
                end else if (r_time > 6'd1) begin
                    w_time_nxt = r_time - 6'd1;
                end else begin
                    w_tout_nxt = 1'b1;
                    w_lose     = 1'b1;
                end
            end
            PAUSED: begin
                if (!pause)
                    w_state_nxt = PLAY;
            end
            GAME_OVER: begin
                w_pack_nxt = w_pass_vld;
                w_fack_nxt = w_fail_vld;
            end
            default: w_state_nxt = IDLE;
        endcase

        if (w_lose) begin
`ifdef GAME_ROUND_LIVES_EN
            if (r_lives <= 2'd1) begin
                w_lives_nxt = 2'd0;
                w_state_nxt = GAME_OVER;
            end else begin
                w_lives_nxt = r_lives - 2'd1;
                w_time_nxt  = round_time(r_level);
                w_nr_nxt    = ~r_new_round;
            end
`else
            w_state_nxt = GAME_OVER;
`endif
        end

        w_pseen_nxt = pass_req & (r_pass_seen | w_pack_nxt);
        w_fseen_nxt = fail_req & (r_fail_seen | w_fack_nxt);
    end

    // Register all game state; reset discards any in-flight event.
    always_ff @(posedge clk1Hz or posedge reset_btn) begin
        if (reset_btn) begin
            r_state     <= IDLE;
            r_time      <= 6'(ROUND_TIME);
            r_score     <= 7'd0;
            r_level     <= 4'd0;
            r_round_cnt <= 7'd0;
            r_new_round <= 1'b0;
            r_pass_ack  <= 1'b0;
            r_fail_ack  <= 1'b0;
            r_timeout   <= 1'b0;
            r_pass_seen <= 1'b0;
            r_fail_seen <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_time      <= w_time_nxt;
            r_score     <= w_score_nxt;
            r_level     <= w_level_nxt;
            r_round_cnt <= w_cnt_nxt;
            r_new_round <= w_nr_nxt;
            r_pass_ack  <= w_pack_nxt;
            r_fail_ack  <= w_fack_nxt;
            r_timeout   <= w_tout_nxt;
            r_pass_seen <= w_pseen_nxt;
            r_fail_seen <= w_fseen_nxt;
        end
    end

`ifdef GAME_ROUND_LIVES_EN
    // Lives counter, reloaded at game start.
    always_ff @(posedge clk1Hz or posedge reset_btn) begin
        if (reset_btn)
            r_lives <= 2'(MAX_LIVES);
        else
            r_lives <= w_lives_nxt;
    end

    assign lives = r_lives;
`else
    assign lives = 2'd0;
`endif

    assign pass_ack  = r_pass_ack;
    assign fail_ack  = r_fail_ack;
    assign new_round = r_new_round;
    assign time_left = r_time;
    assign score     = r_score;
    assign level     = r_level;
    assign timeout   = r_timeout;
    assign game_over = (r_state == GAME_OVER);

endmodule
